// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port count, default downstream buffer depth,
// port index constants and the output allocator state encoding.
package noc_pkg;

  localparam int NUM_PORTS       = 5;
  localparam int DEFAULT_CREDITS = 4;

  // Router port indices
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational rotate-priority picker: returns the first asserted request
// found when searching ptr+1, ptr+2, ... modulo NUM_IN. Shared with the VC
// allocator, so it holds no state of its own.
module noc_rr_pick #(
  parameter int NUM_IN = 5,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SELW-1:0]   ptr,
  output logic              any,
  output logic [SELW-1:0]   winner
);

  // Scan farthest-first so the nearest asserted input after ptr overwrites the rest
  always_comb begin
    int idx;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_IN;
      if (req[idx[SELW-1:0]]) begin
        any    = 1'b1;
        winner = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_rr_output_alloc.sv
// Output-port allocator for one router output: round-robin grant among the
// inputs, grant held for a whole packet, flit transfers gated by downstream
// credits. Drives the crossbar mux through sel.
module noc_rr_output_alloc
  import noc_pkg::*;
#(
  parameter int NUM_IN  = NUM_PORTS,
  parameter int CREDITS = DEFAULT_CREDITS,
  parameter int SELW    = $clog2(NUM_IN),
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] flit_valid,
  input  logic [NUM_IN-1:0] flit_tail,
  input  logic              credit_in,
  output logic [NUM_IN-1:0] gnt,
  output logic [SELW-1:0]   sel,
  output logic              fire,
  output logic [CW-1:0]     credit_cnt,
  output logic              cr_ovf
);

  localparam logic [SELW-1:0] PTR_RESET = SELW'(NUM_IN - 1);
  localparam logic [CW-1:0]   CRED_MAX  = CW'(CREDITS);

  alloc_state_t      state_reg, state_next;
  logic [NUM_IN-1:0] gnt_reg, gnt_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [SELW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]     credit_reg, credit_next;
  logic              ovf_reg, ovf_next;

  logic              pick_any;
  logic [SELW-1:0]   pick_winner;
  logic [NUM_IN-1:0] pick_onehot;
  logic              fire_int;

  noc_rr_pick #(
    .NUM_IN (NUM_IN),
    .SELW   (SELW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .any    (pick_any),
    .winner (pick_winner)
  );

  // Decode the picked index into the one-hot grant pattern
  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_winner == SELW'(gi));
    end
  endgenerate

  // A flit moves only while a packet owns the port and a downstream slot is free
  assign fire_int = (state_reg == BUSY) && flit_valid[sel_reg] && (credit_reg != '0);

  // Grant FSM: win in IDLE, release on tail fire or when the owner drops req
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (pick_any) begin
          state_next = BUSY;
          gnt_next   = pick_onehot;
          sel_next   = pick_winner;
        end
      end
      BUSY: begin
        if ((fire_int && flit_tail[sel_reg]) || !req[sel_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = sel_reg;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // Credit bookkeeping: a fire and a returned credit in the same cycle cancel
  always_comb begin
    credit_next = credit_reg;
    ovf_next    = ovf_reg;
    if (fire_int && !credit_in) begin
      credit_next = credit_reg - CW'(1);
    end else if (credit_in && !fire_int) begin
      if (credit_reg == CRED_MAX) begin
        ovf_next = 1'b1;
      end else begin
        credit_next = credit_reg + CW'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      sel_reg    <= '0;
      ptr_reg    <= PTR_RESET;
      credit_reg <= CRED_MAX;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      sel_reg    <= sel_next;
      ptr_reg    <= ptr_next;
      credit_reg <= credit_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign gnt        = gnt_reg;
  assign sel        = sel_reg;
  assign fire       = fire_int;
  assign credit_cnt = credit_reg;
  assign cr_ovf     = ovf_reg;

endmodule
